// File: rtl/aes_key_sched_ctrl.sv
// AES-256 key-schedule controller: sequences one expansion run and keeps the 15 round keys.
// Optional zeroize input is compiled in when AES_KSC_ZEROIZE_EN is defined.
module aes_key_sched_ctrl #(
   parameter int RK_W   = 128,
   parameter int NUM_RK = 15,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              resetn,
`ifdef AES_KSC_ZEROIZE_EN
   input  logic              zeroize,
`endif
   input  logic              key_load,
   input  logic [2*RK_W-1:0] key_in,
   output logic              busy,
   output logic              key_ready,
   output logic              exp_start,
   output logic [2*RK_W-1:0] exp_key,
   input  logic [RK_W-1:0]   exp_subkey,
   input  logic [3:0]        exp_cnt,
   input  logic              exp_valid,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [RK_W-1:0]   rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              exp_err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] START   = 2'd1;
   localparam logic [1:0] COLLECT = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [3:0]       LAST_CNT = 4'(NUM_RK - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

   logic [1:0]          state_q, state_d;
   logic                exp_err_q, exp_err_d;
   logic [2*RK_W-1:0]   exp_key_q;
   logic [RK_W-1:0]     rk_q [NUM_RK];
   logic [RK_W-1:0]     rd_data_q;
   logic                rd_valid_q, rd_err_q;
   logic                zero_w, load_w, wr_w, rd_ok_w;

`ifdef AES_KSC_ZEROIZE_EN
   assign zero_w = zeroize;
`else
   assign zero_w = 1'b0;
`endif

   // A load is only honoured when no run is in flight.
   assign load_w  = key_load && !zero_w &&
                    (state_q == IDLE || state_q == DONE);
   assign wr_w    = !zero_w && state_q == COLLECT && exp_valid &&
                    exp_cnt != 4'd0 && exp_cnt <= LAST_CNT;
   assign rd_ok_w = !zero_w && state_q == DONE && rd_idx <= LAST_IDX;

   always_comb begin
      state_d   = state_q;
      exp_err_d = exp_err_q;
      case (state_q)
         IDLE, DONE: begin
            if (load_w) begin
               state_d   = START;
               exp_err_d = 1'b0;
            end
         end
         START: state_d = COLLECT;
         COLLECT: begin
            if (!exp_valid) begin
               state_d   = IDLE;
               exp_err_d = 1'b1;
            end else if (wr_w && exp_cnt == LAST_CNT) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (zero_w) begin
         state_d   = IDLE;
         exp_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         exp_err_q  <= 1'b0;
         exp_key_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_err_q  <= exp_err_d;
         rd_valid_q <= rd_en && rd_ok_w;
         rd_err_q   <= rd_en && !rd_ok_w;
         if (rd_en && rd_ok_w) rd_data_q <= rk_q[rd_idx];
         if (zero_w)      exp_key_q <= '0;
         else if (load_w) exp_key_q <= key_in;
      end
   end

   // Store is pure datapath: contents are don't-care until key_ready.
   always_ff @(posedge clk) begin
      if (zero_w) begin
         for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
      end else begin
         if (load_w) rk_q[0] <= key_in[2*RK_W-1:RK_W];
         if (wr_w)   rk_q[exp_cnt] <= exp_subkey;
      end
   end

   assign busy      = (state_q == START) || (state_q == COLLECT);
   assign key_ready = (state_q == DONE);
   assign exp_start = (state_q == START);
   assign exp_key   = exp_key_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign rd_err    = rd_err_q;
   assign exp_err   = exp_err_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Controller for the 256-bit AES key-expansion datapath. It accepts a 256-bit cipher key and sequences one expansion run. It captures all 15 round keys into a local round-key store and serves random-access reads to the cipher round engine. It sits between the AXI4-Lite register front end (key load) and the round engine (key reads).

Parameters:
RK_W, 128, round-key width in bits
NUM_RK, 15, number of round keys (AES-256)
IDX_W, 4, round-key index width

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous, active-low reset
key_load  in  1  one-cycle pulse; samples key_in
key_in  in  256  cipher key; [255:128] is words w0..w3
busy  out  1  expansion in progress
key_ready  out  1  all NUM_RK round keys valid in store
exp_start  out  1  start pulse to expander
exp_key  out  256  key to expander (registered copy of key_in)
exp_subkey  in  RK_W  expander round-key output
exp_cnt  in  4  expander round counter (1..14 while valid)
exp_valid  in  1  expander status/valid
rd_en  in  1  read request
rd_idx  in  IDX_W  round-key index 0..14
rd_data  out  RK_W  registered round key
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_err  out  1  one-cycle pulse, read rejected
exp_err  out  1  sticky: expander dropped valid early; cleared by next key_load

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE. All outputs 0. Store contents don't-care, but reads are rejected until key_ready.
- FSM states: IDLE, START, COLLECT, DONE.
- IDLE or DONE with key_load=1 at edge L:
  - latch key_in into exp_key
  - write entry 0 = key_in[255:128]
  - key_ready<=0, busy<=1, exp_err<=0
  - go to START.
- START: exp_start=1 for exactly this cycle. Always go to COLLECT on the next edge (L+1).
- COLLECT: on each edge with exp_valid=1 and exp_cnt in 1..14, write entry[exp_cnt]=exp_subkey.
  - Expander timing: entry 1 (= key_in[127:0]) is written at L+2, entries 2..14 at L+3..L+15.
  - The write with exp_cnt=14 moves the FSM to DONE, sets key_ready<=1 and busy<=0. key_ready is high 15 cycles after the load edge.
- COLLECT abort: if exp_valid=0 at any edge in COLLECT before entry 14 is written, set exp_err<=1 and busy<=0, and return to IDLE. key_ready stays 0.
- COLLECT ignores edges with exp_cnt=0 while exp_valid=1; no write occurs.
- key_load while busy (START/COLLECT): ignored, no effect on the run.
- key_load in DONE: key_ready drops at the next edge, and a new run starts as above.
- Read port, 1-cycle latency:
  - rd_en=1 at edge R with key_ready=1 and rd_idx<=14: rd_data<=entry[rd_idx] and rd_valid=1 during the cycle after R.
  - Otherwise (not ready, or rd_idx=15): rd_err=1 for one cycle, rd_valid=0, rd_data holds its previous value.
  - Back-to-back reads are allowed every cycle.
- Simultaneous rd_en and key_load in DONE: the read is served from the old store (entry 0 write and read target differ only if rd_idx=0; read returns the pre-write value). Later reads are rejected until the new key_ready.
- exp_start is never asserted outside START. The controller never drives the expander reset.

Optional Feature:
AES_KSC_ZEROIZE_EN:
- Defined: adds input port zeroize (1 bit).
- zeroize=1 at any edge clears all NUM_RK entries and exp_key to 0 in that cycle. It also forces IDLE with key_ready=0, busy=0, exp_err=0, and takes priority over key_load and rd_en (rd_err pulses if rd_en was set).
- If asserted during COLLECT, later expander outputs are ignored.
- Undefined: port absent; the store retains keys until overwritten.

Test Plan:
- Load key 000102…1f at edge L -> exp_start high L..L+1 only, busy=1, key_ready=1 from L+15; then read idx0 = 000102030405060708090a0b0c0d0e0f, idx1 = 101112131415161718191a1b1c1d1e1f, idx14 = 24fc79ccbf0979e9371ac23c6d68de36, each with rd_valid one cycle after rd_en.
- rd_en with rd_idx=3 at L+5 (mid-run), then rd_idx=15 after ready -> rd_err pulse both times, rd_valid=0, rd_data unchanged.
- Second key_load at L+7 during a run -> ignored; key_ready at L+15; entries match the first key.
- Force exp_valid=0 at L+9 -> exp_err=1, FSM IDLE, key_ready=0. Next key_load clears exp_err and completes normally.
- resetn low at L+8 -> all outputs 0 immediately (asynchronous). After release, reads give rd_err until a new load completes.
- With AES_KSC_ZEROIZE_EN: zeroize in DONE -> key_ready=0 next cycle. After reload, store contents match FIPS-197 C.3.
